output_fetch_stream: RTL and testbench
======================================

OUTPUT_FETCH_STREAM -- requirements
Module: output_fetch_stream

Interface
REQ-001 SHALL have parameter BUS_W, default 128: memory read-bus width in bits.
REQ-002 SHALL have parameter PIX_W, default 8: pixel width; BUS_W a multiple of PIX_W; LANES = BUS_W/PIX_W.
REQ-003 SHALL have parameter ADDR_W, default 16: read-address width; MSB is the bank bit.
REQ-004 SHALL have parameter DOUT_W, default 16: output word width, DOUT_W >= PIX_W+1.
REQ-005 SHALL have parameter NUM_WORDS, default 19200: bus words per frame, 1..2^(ADDR_W-1).
REQ-006 SHALL have parameter READ_LAT, default 1: memory read latency in cycles, >= 1.
REQ-007 SHALL have parameter DONE_DELAY, default 12: cycles from last pixel accepted to done, >= 1.
REQ-008 SHALL have port clock  input  1  sole clock, rising edge.
REQ-009 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-010 SHALL have port start  input  1  frame request, sampled in IDLE/DONE only.
REQ-011 SHALL have port abort  input  1  synchronous abort, returns to IDLE.
REQ-012 SHALL have port output_base_offset  input  1  bank select, latched at accepted start.
REQ-013 SHALL have port ReadBus  input  BUS_W  memory read data.
REQ-014 SHALL have port ReadAddress  output  ADDR_W  memory read address, registered.
REQ-015 SHALL have port out_ready  input  1  downstream accepts DataOut.
REQ-016 SHALL have port DataOut  output  DOUT_W  {bank, zeros, pixel}.
REQ-017 SHALL have port StartOut  output  1  DataOut valid.
REQ-018 SHALL have port done  output  1  frame complete, level.

Function
REQ-019 SHALL implement states IDLE, FETCH, SERIAL, DRAIN, DONE.
REQ-020 IDLE/DONE + start: latch bank, ReadAddress <= {bank, 0}, word_cnt <= 0, done <= 0, -> FETCH.
REQ-021 FETCH lasts READ_LAT+1 cycles from the first cycle ReadAddress holds the new value; on its final edge ReadBus is captured into data register, lane <= 0, -> SERIAL.
REQ-022 SERIAL: StartOut = 1; DataOut = {bank, (DOUT_W-PIX_W-1) zeros, data[lane*PIX_W +: PIX_W]}; lane 0 is least significant.
REQ-023 Transfer occurs on StartOut & out_ready; lane increments per transfer; with out_ready low, DataOut/StartOut/lane held stable.
REQ-024 Transfer on lane LANES-1 with word_cnt < NUM_WORDS-1: word_cnt++, ReadAddress low ADDR_W-1 bits ++ (bank bit unchanged), -> FETCH.
REQ-025 Transfer on lane LANES-1 with word_cnt == NUM_WORDS-1: ReadAddress held, -> DRAIN.
REQ-026 Frame end SHALL be decided by word_cnt, never by comparing ReadAddress including bank bit.
REQ-027 DRAIN: StartOut = 0; counts DONE_DELAY cycles, then -> DONE with done = 1 in that same edge.
REQ-028 DONE: done held 1, StartOut 0, until accepted start (done 0 next cycle) or abort.
REQ-029 start in FETCH/SERIAL/DRAIN SHALL be ignored; output_base_offset changes mid-frame SHALL not affect bank.
REQ-030 abort in any state: next cycle IDLE, StartOut 0, done 0, lane/word_cnt 0; abort wins over simultaneous start.
REQ-031 IDLE: StartOut 0, ReadAddress tracks {output_base_offset, 0}, DataOut 0.
REQ-032 Throughput: LANES transfers per word plus READ_LAT+1 bubble cycles, with out_ready held high.

Reset
REQ-033 reset_n low SHALL asynchronously force IDLE, ReadAddress 0, DataOut 0, StartOut 0, done 0, all counters and data register 0, mid-frame included.

Verification
REQ-034 BUS_W=32, NUM_WORDS=2, READ_LAT=1, out_ready=1, bank=0, words 0x44332211/0x88776655 -> DataOut low bytes 11,22,33,44,55,66,77,88; 2-cycle bubble between words; done high DONE_DELAY cycles after 88 accepted.
REQ-035 Same, bank=1 -> ReadAddress 0x8000 then 0x8001; every DataOut bit15 = 1; frame ends after 2 words.
REQ-036 out_ready low 3 cycles during lane 2 -> DataOut 0x0033 and StartOut held 3 cycles, no byte lost or repeated.
REQ-037 abort during SERIAL lane 1, simultaneous start -> IDLE next cycle, StartOut 0, done 0; later start restarts at address 0.
REQ-038 reset_n low mid-SERIAL -> all outputs 0 immediately, without a clock edge; start in DONE -> done 0 next cycle, new frame streams.

Source files
------------

// File: rtl/output_fetch_stream_if.sv
// Memory read port plus the pixel output stream of output_fetch_stream.
// master = the fetch engine, slave = memory/downstream side.
interface output_fetch_stream_if #(
   parameter int unsigned BUS_W  = 128,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DOUT_W = 16
) ();
   logic [BUS_W-1:0]  ReadBus;
   logic [ADDR_W-1:0] ReadAddress;
   logic              out_ready;
   logic [DOUT_W-1:0] DataOut;
   logic              StartOut;

   modport master (
      input  ReadBus,
      input  out_ready,
      output ReadAddress,
      output DataOut,
      output StartOut
   );

   modport slave (
      output ReadBus,
      output out_ready,
      input  ReadAddress,
      input  DataOut,
      input  StartOut
   );
endinterface

// File: rtl/output_fetch_stream.sv
// Fetches a frame of bus words from a banked memory and serialises each word into pixels,
// lane 0 first, tagging every output with the bank bit.
module output_fetch_stream #(
   parameter int unsigned BUS_W      = 128,
   parameter int unsigned PIX_W      = 8,
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned DOUT_W     = 16,
   parameter int unsigned NUM_WORDS  = 19200,
   parameter int unsigned READ_LAT   = 1,
   parameter int unsigned DONE_DELAY = 12
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   output_base_offset,
   output_fetch_stream_if.master  bus,
   output logic                   done
);

   localparam int unsigned LANES  = BUS_W / PIX_W;
   localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned FCNT_W = $clog2(READ_LAT + 1);
   localparam int unsigned DCNT_W = $clog2(DONE_DELAY + 1);

   typedef enum logic [2:0] {StIdle, StFetch, StSerial, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic                bank_q, bank_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [BUS_W-1:0]    data_q, data_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
   logic                done_q, done_d;
   logic [PIX_W-1:0]    pixel;
   logic [DOUT_W-1:0]   dout;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         bank_q     <= 1'b0;
         addr_q     <= '0;
         word_cnt_q <= '0;
         lane_q     <= '0;
         data_q     <= '0;
         fcnt_q     <= '0;
         dcnt_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bank_q     <= bank_d;
         addr_q     <= addr_d;
         word_cnt_q <= word_cnt_d;
         lane_q     <= lane_d;
         data_q     <= data_d;
         fcnt_q     <= fcnt_d;
         dcnt_q     <= dcnt_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bank_d     = bank_q;
      addr_d     = addr_q;
      word_cnt_d = word_cnt_q;
      lane_d     = lane_q;
      data_d     = data_q;
      fcnt_d     = fcnt_q;
      dcnt_d     = dcnt_q;
      done_d     = done_q;

      if (abort) begin
         state_d    = StIdle;
         addr_d     = {output_base_offset, {(ADDR_W-1){1'b0}}};
         word_cnt_d = '0;
         lane_d     = '0;
         data_d     = '0;
         fcnt_d     = '0;
         dcnt_d     = '0;
         done_d     = 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (state_q == StIdle) begin
                  addr_d = {output_base_offset, {(ADDR_W-1){1'b0}}};
               end
               if (start) begin
                  state_d    = StFetch;
                  bank_d     = output_base_offset;
                  addr_d     = {output_base_offset, {(ADDR_W-1){1'b0}}};
                  word_cnt_d = '0;
                  fcnt_d     = '0;
                  done_d     = 1'b0;
               end
            end
            StFetch: begin
               // Final fetch cycle: memory data for addr_q is valid on ReadBus now.
               if (fcnt_q == FCNT_W'(READ_LAT)) begin
                  state_d = StSerial;
                  data_d  = bus.ReadBus;
                  lane_d  = '0;
                  fcnt_d  = '0;
               end else begin
                  fcnt_d = fcnt_q + FCNT_W'(1);
               end
            end
            StSerial: begin
               if (bus.out_ready) begin
                  if (lane_q == LANE_W'(LANES - 1)) begin
                     lane_d = '0;
                     if (word_cnt_q == ADDR_W'(NUM_WORDS - 1)) begin
                        state_d = StDrain;
                        dcnt_d  = '0;
                     end else begin
                        state_d    = StFetch;
                        word_cnt_d = word_cnt_q + ADDR_W'(1);
                        addr_d     = {bank_q, addr_q[ADDR_W-2:0] + (ADDR_W-1)'(1)};
                        fcnt_d     = '0;
                     end
                  end else begin
                     lane_d = lane_q + LANE_W'(1);
                  end
               end
            end
            StDrain: begin
               if (dcnt_q == DCNT_W'(DONE_DELAY - 1)) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end else begin
                  dcnt_d = dcnt_q + DCNT_W'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      pixel = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         if (lane_q == LANE_W'(i)) pixel = data_q[i*PIX_W +: PIX_W];
      end
      dout = '0;
      if (state_q == StSerial) begin
         dout[PIX_W-1:0]  = pixel;
         dout[DOUT_W-1]   = bank_q;
      end
   end

   assign bus.ReadAddress = addr_q;
   assign bus.DataOut     = dout;
   assign bus.StartOut    = (state_q == StSerial);
   assign done            = done_q;

endmodule

// File: tb/tb_output_fetch_stream.sv
// Directed bench for output_fetch_stream: 32-bit bus, 2-word frames, 1-cycle memory latency.
module tb_output_fetch_stream;

   logic clock;
   logic reset_n;
   logic start;
   logic abort;
   logic output_base_offset;
   logic done;
   logic [31:0] mem [2];
   int vectors;
   int miscompares;

   output_fetch_stream_if #(.BUS_W(32), .ADDR_W(16), .DOUT_W(16)) bus ();

   output_fetch_stream #(
      .BUS_W(32), .PIX_W(8), .ADDR_W(16), .DOUT_W(16),
      .NUM_WORDS(2), .READ_LAT(1), .DONE_DELAY(4)
   ) dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .start              (start),
      .abort              (abort),
      .output_base_offset (output_base_offset),
      .bus                (bus),
      .done               (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One-cycle registered read memory; index by word bits below the bank bit.
   always @(posedge clock) bus.ReadBus <= mem[bus.ReadAddress[0]];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Streams one whole frame from an accepted start through done.
   task automatic frame(input logic bnk, input int stall, input logic noise);
      logic [7:0] b [8];
      logic [31:0] exp;
      b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      output_base_offset = bnk;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("acc_startout", {31'h0, bus.StartOut}, 32'h0);
      check("acc_addr", {16'h0, bus.ReadAddress}, {16'h0, bnk, 15'h0});
      check("acc_done", {31'h0, done}, 32'h0);
      if (noise) begin
         start = 1'b1;
         output_base_offset = ~bnk;
      end
      tick();
      check("fetch2_startout", {31'h0, bus.StartOut}, 32'h0);
      tick();
      for (int w = 0; w < 2; w++) begin
         if (w == 1) begin
            check("word1_addr", {16'h0, bus.ReadAddress}, {16'h0, bnk, 15'h1});
            check("bubble1_startout", {31'h0, bus.StartOut}, 32'h0);
            tick();
            check("bubble2_startout", {31'h0, bus.StartOut}, 32'h0);
            tick();
         end
         for (int l = 0; l < 4; l++) begin
            exp = {16'h0, bnk, 7'h0, b[w*4+l]};
            check("pixel", {16'h0, bus.DataOut}, exp);
            check("pixel_startout", {31'h0, bus.StartOut}, 32'h1);
            if (w*4 + l == stall) begin
               bus.out_ready = 1'b0;
               repeat (3) begin
                  tick();
                  check("stall_pixel", {16'h0, bus.DataOut}, exp);
                  check("stall_startout", {31'h0, bus.StartOut}, 32'h1);
               end
               bus.out_ready = 1'b1;
            end
            tick();
         end
      end
      for (int k = 0; k < 4; k++) begin
         check("drain_done", {31'h0, done}, 32'h0);
         check("drain_startout", {31'h0, bus.StartOut}, 32'h0);
         check("drain_dataout", {16'h0, bus.DataOut}, 32'h0);
         tick();
      end
      check("done_high", {31'h0, done}, 32'h1);
      check("done_startout", {31'h0, bus.StartOut}, 32'h0);
      start = 1'b0;
      output_base_offset = bnk;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      mem[0] = 32'h4433_2211;
      mem[1] = 32'h8877_6655;
      reset_n = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      output_base_offset = 1'b0;
      bus.out_ready = 1'b1;
      #2 reset_n = 1'b0;
      #10;
      check("rst_addr", {16'h0, bus.ReadAddress}, 32'h0);
      check("rst_dataout", {16'h0, bus.DataOut}, 32'h0);
      check("rst_startout", {31'h0, bus.StartOut}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      reset_n = 1'b1;
      tick();
      check("idle_addr0", {16'h0, bus.ReadAddress}, 32'h0);
      output_base_offset = 1'b1;
      tick();
      check("idle_track_bank1", {16'h0, bus.ReadAddress}, 32'h8000);
      check("idle_dataout", {16'h0, bus.DataOut}, 32'h0);
      output_base_offset = 1'b0;
      tick();
      check("idle_track_bank0", {16'h0, bus.ReadAddress}, 32'h0);

      // Bank 0 frame, then bank 1 started from DONE with mid-frame start/bank noise.
      frame(1'b0, -1, 1'b0);
      frame(1'b1, -1, 1'b1);
      // Downstream stall on lane 2 (pixel 0x33).
      frame(1'b0, 2, 1'b0);

      // Abort with simultaneous start while lane 1 is presented.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check("pre_abort_pixel", {16'h0, bus.DataOut}, 32'h22);
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check("abort_startout", {31'h0, bus.StartOut}, 32'h0);
      check("abort_done", {31'h0, done}, 32'h0);
      check("abort_dataout", {16'h0, bus.DataOut}, 32'h0);
      tick();
      check("abort_stays_idle", {31'h0, bus.StartOut}, 32'h0);
      check("abort_idle_addr", {16'h0, bus.ReadAddress}, 32'h0);
      frame(1'b0, -1, 1'b0);

      // Asynchronous reset in the middle of SERIAL, between clock edges.
      output_base_offset = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check("pre_reset_pixel", {16'h0, bus.DataOut}, 32'h8022);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_addr", {16'h0, bus.ReadAddress}, 32'h0);
      check("async_rst_dataout", {16'h0, bus.DataOut}, 32'h0);
      check("async_rst_startout", {31'h0, bus.StartOut}, 32'h0);
      check("async_rst_done", {31'h0, done}, 32'h0);
      reset_n = 1'b1;
      tick();
      frame(1'b1, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
